// File: rtl/rst_seq_pkg.sv
// rst_seq_pkg: state encoding, soft-reset counter limits and default parameters for rst_seq_mon
package rst_seq_pkg;

    localparam logic [1:0] ST_HOLD    = 2'd0;
    localparam logic [1:0] ST_RELEASE = 2'd1;
    localparam logic [1:0] ST_DONE    = 2'd2;
    localparam logic [1:0] ST_SOFT    = 2'd3;

    typedef enum logic [1:0] {
        HOLD    = ST_HOLD,
        RELEASE = ST_RELEASE,
        DONE    = ST_DONE,
        SOFT    = ST_SOFT
    } rst_seq_state_e;

    localparam int SOFT_CNT_W = 8;
    localparam logic [SOFT_CNT_W-1:0] SOFT_CNT_MAX = 8'd255;

    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_NUM_STAGES  = 3;
    localparam int DEF_STAGE_GAP   = 4;
    localparam int DEF_SOFT_CYCLES = 8;
    localparam int DEF_HB_LOG2     = 4;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/rst_sync_chain.sv
// rst_sync_chain: async-assert, sync-deassert reset synchronizer (active-low in and out)
module rst_sync_chain #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    output logic rst_sync_n
);

    logic [SYNC_STAGES-1:0] ff;

    // shift ones in after rst rises; any rst low clears the whole chain immediately
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            ff <= '0;
        else
            ff <= {ff[SYNC_STAGES-2:0], 1'b1};
    end

    assign rst_sync_n = ff[SYNC_STAGES-1];

endmodule

// File: rtl/rst_seq_mon.sv
// rst_seq_mon: reset synchronizer plus staged subsystem reset release with soft reset; heartbeat under RST_SEQ_MON_HEARTBEAT_EN
module rst_seq_mon
    import rst_seq_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int NUM_STAGES  = DEF_NUM_STAGES,
    parameter int STAGE_GAP   = DEF_STAGE_GAP,
    parameter int SOFT_CYCLES = DEF_SOFT_CYCLES,
    parameter int HB_LOG2     = DEF_HB_LOG2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sw_rst_req,
    output logic                  rst_sync_n,
    output logic [NUM_STAGES-1:0] rst_stage_n,
    output logic                  rst_done,
    output logic                  busy,
    output logic [SOFT_CNT_W-1:0] soft_cnt,
    output logic                  hb
);

    localparam int GW    = $clog2(max_int(STAGE_GAP, SOFT_CYCLES)) + 1;
    localparam int IDX_W = $clog2(NUM_STAGES) + 1;
    localparam logic [GW-1:0]    GAP_LAST  = GW'(STAGE_GAP - 1);
    localparam logic [GW-1:0]    SOFT_LAST = GW'(SOFT_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_STAGES - 1);

    if (SYNC_STAGES < 2 || NUM_STAGES < 1 || STAGE_GAP < 1 || SOFT_CYCLES < 1 || HB_LOG2 < 1) begin : g_bad_param
        $error("rst_seq_mon: parameter below its minimum");
    end

    logic [1:0]       state;
    logic [GW-1:0]    gap_cnt;
    logic [IDX_W-1:0] idx;
    logic             start;
    logic             adv;
    logic             last;
    logic             soft_go;

    rst_sync_chain #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk        (clk),
        .rst        (rst),
        .rst_sync_n (rst_sync_n)
    );

    // start releases stage 0 (from HOLD or at the end of a soft hold); adv releases the next stage
    assign start   = (state == ST_HOLD && rst_sync_n) || (state == ST_SOFT && gap_cnt == SOFT_LAST);
    assign adv     = state == ST_RELEASE && gap_cnt == GAP_LAST;
    assign last    = start ? (NUM_STAGES == 1) : (idx == IDX_LAST);
    assign soft_go = state == ST_DONE && sw_rst_req;

    // sequencer: shifting a one into the stage vector keeps it thermometer-coded
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_HOLD;
            busy        <= 1'b1;
            rst_stage_n <= '0;
            rst_done    <= 1'b0;
            gap_cnt     <= '0;
            idx         <= '0;
            soft_cnt    <= '0;
        end else if (start || adv) begin
            rst_stage_n <= NUM_STAGES'({rst_stage_n, 1'b1});
            idx         <= start ? IDX_W'(1) : idx + 1'b1;
            gap_cnt     <= '0;
            state       <= last ? ST_DONE : ST_RELEASE;
            busy        <= !last;
            rst_done    <= last;
        end else if (soft_go) begin
            rst_stage_n <= '0;
            rst_done    <= 1'b0;
            state       <= ST_SOFT;
            busy        <= 1'b1;
            gap_cnt     <= '0;
            soft_cnt    <= (soft_cnt == SOFT_CNT_MAX) ? soft_cnt : soft_cnt + 1'b1;
        end else if (state == ST_RELEASE || state == ST_SOFT) begin
            gap_cnt     <= gap_cnt + 1'b1;
        end
    end

`ifdef RST_SEQ_MON_HEARTBEAT_EN
    logic [HB_LOG2-1:0] hb_cnt;
    logic               hb_q;

    // free-running heartbeat counter, parked at zero until every stage is out of reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hb_cnt <= '0;
            hb_q   <= 1'b0;
        end else if (!rst_done) begin
            hb_cnt <= '0;
            hb_q   <= 1'b0;
        end else begin
            hb_cnt <= hb_cnt + 1'b1;
            hb_q   <= (&hb_cnt) ? !hb_q : hb_q;
        end
    end

    assign hb = hb_q & rst_done;
`else
    assign hb = 1'b0;
`endif

endmodule

// File: tb/tb_rst_seq_mon.sv
// tb_rst_seq_mon: directed self-checking bench for rst_seq_mon with default parameters
module tb_rst_seq_mon;

`ifdef RST_SEQ_MON_HEARTBEAT_EN
    localparam bit HB_ON = 1'b1;
`else
    localparam bit HB_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       sw_rst_req = 1'b0;
    logic       rst_sync_n;
    logic [2:0] rst_stage_n;
    logic       rst_done;
    logic       busy;
    logic [7:0] soft_cnt;
    logic       hb;
    int         n_chk = 0;
    int         n_fail = 0;

    // {rst_sync_n, rst_stage_n[2:0], rst_done, busy, soft_cnt[7:0], hb}
    wire [14:0] obs = {rst_sync_n, rst_stage_n, rst_done, busy, soft_cnt, hb};
    localparam logic [14:0] RESET_OBS = {1'b0, 3'b000, 1'b0, 1'b1, 8'd0, 1'b0};

    rst_seq_mon dut (
        .clk         (clk),
        .rst         (rst),
        .sw_rst_req  (sw_rst_req),
        .rst_sync_n  (rst_sync_n),
        .rst_stage_n (rst_stage_n),
        .rst_done    (rst_done),
        .busy        (busy),
        .soft_cnt    (soft_cnt),
        .hb          (hb)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        sw_rst_req = 1'b0;
        repeat (3) step();
        rst = 1'b1;
    endtask

    // walks E1..E11 after rst rises; soft_cnt is expected to be zero here
    task automatic check_seq(input string tag);
        logic [2:0]  st;
        logic [14:0] exp;
        for (int e = 1; e <= 11; e++) begin
            step();
            st  = (e >= 11) ? 3'b111 : (e >= 7) ? 3'b011 : (e >= 3) ? 3'b001 : 3'b000;
            exp = {(e >= 2), st, (e >= 11), (e < 11), 8'd0, 1'b0};
            n_chk++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL %s E%0d: got %b expected %b", tag, e, obs, exp);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (5) step();
        n_chk++;
        if (obs !== RESET_OBS) begin
            n_fail++;
            $display("FAIL reset_values: got %b expected %b", obs, RESET_OBS);
        end
        rst = 1'b1;
    endtask

    task automatic test_release();
        check_seq("release");
    endtask

    task automatic test_soft();
        logic [2:0]  st;
        logic [14:0] exp;
        sw_rst_req = 1'b1;
        step();
        sw_rst_req = 1'b0;
        exp = {1'b1, 3'b000, 1'b0, 1'b1, 8'd1, 1'b0};
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL soft_entry: got %b expected %b", obs, exp);
        end
        for (int k = 1; k <= 16; k++) begin
            step();
            st  = (k >= 16) ? 3'b111 : (k >= 12) ? 3'b011 : (k >= 8) ? 3'b001 : 3'b000;
            exp = {1'b1, st, (k >= 16), (k < 16), 8'd1, 1'b0};
            n_chk++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL soft_seq Q+%0d: got %b expected %b", k, obs, exp);
            end
        end
    endtask

    task automatic test_async_reset();
        logic [14:0] exp;
        do_reset();
        repeat (8) step();
        exp = {1'b1, 3'b011, 1'b0, 1'b1, 8'd0, 1'b0};
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL pre_async E8: got %b expected %b", obs, exp);
        end
        rst = 1'b0;
        #2;
        n_chk++;
        if (obs !== RESET_OBS) begin
            n_fail++;
            $display("FAIL async_clear: got %b expected %b", obs, RESET_OBS);
        end
        repeat (2) step();
        rst = 1'b1;
        check_seq("restart");
    endtask

    task automatic test_req_early();
        logic [14:0] exp;
        rst = 1'b0;
        sw_rst_req = 1'b1;
        repeat (2) step();
        rst = 1'b1;
        check_seq("req_held");
        step();
        exp = {1'b1, 3'b000, 1'b0, 1'b1, 8'd1, 1'b0};
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL req_first_done: got %b expected %b", obs, exp);
        end
        sw_rst_req = 1'b0;
        repeat (16) step();
        exp = {1'b1, 3'b111, 1'b1, 1'b0, 8'd1, 1'b0};
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL req_redone: got %b expected %b", obs, exp);
        end
    endtask

    task automatic test_saturation();
        logic [7:0]  exp_cnt;
        logic [14:0] exp;
        do_reset();
        repeat (11) step();
        for (int i = 0; i < 260; i++) begin
            sw_rst_req = 1'b1;
            step();
            sw_rst_req = 1'b0;
            exp_cnt = (i + 1 > 255) ? 8'd255 : 8'(i + 1);
            if (i < 2 || i >= 253) begin
                n_chk++;
                if (soft_cnt !== exp_cnt) begin
                    n_fail++;
                    $display("FAIL soft_cnt #%0d: got %0d expected %0d", i + 1, soft_cnt, exp_cnt);
                end
            end
            repeat (16) step();
        end
        exp = {1'b1, 3'b111, 1'b1, 1'b0, 8'd255, 1'b0};
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL saturated_done: got %b expected %b", obs, exp);
        end
        rst = 1'b0;
        #2;
        n_chk++;
        if (obs !== RESET_OBS) begin
            n_fail++;
            $display("FAIL sat_clear: got %b expected %b", obs, RESET_OBS);
        end
        step();
        rst = 1'b1;
    endtask

    task automatic test_heartbeat();
        do_reset();
        repeat (11) step();
        repeat (15) step();
        n_chk++;
        if (hb !== 1'b0) begin
            n_fail++;
            $display("FAIL hb E26: got %b expected 0", hb);
        end
        step();
        n_chk++;
        if (hb !== HB_ON) begin
            n_fail++;
            $display("FAIL hb E27: got %b expected %b", hb, HB_ON);
        end
        repeat (15) step();
        n_chk++;
        if (hb !== HB_ON) begin
            n_fail++;
            $display("FAIL hb E42: got %b expected %b", hb, HB_ON);
        end
        step();
        n_chk++;
        if (hb !== 1'b0) begin
            n_fail++;
            $display("FAIL hb E43: got %b expected 0", hb);
        end
    endtask

    initial begin
        test_reset();
        test_release();
        test_soft();
        test_async_reset();
        test_req_early();
        test_saturation();
        test_heartbeat();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/rst_seq_mon.md
Name: rst_seq_mon

Overview:
- Consumer end of the clock/reset generator's clk/rst pair.
- Takes the raw asynchronous active-low reset and produces a synchronized reset.
- Releases a staged, per-subsystem reset vector in a fixed order.
- Supports a software-requested soft reset and counts soft resets.
- Sits at the top of the full-system design, between clock/reset generation and the subsystem reset pins.

Parameters:
- SYNC_STAGES, 2, flops in the reset synchronizer chain; minimum 2.
- NUM_STAGES, 3, number of staged reset outputs; minimum 1.
- STAGE_GAP, 4, clk cycles between consecutive stage releases; minimum 1.
- SOFT_CYCLES, 8, clk cycles that all stages are held asserted for a soft reset; minimum 1.
- HB_LOG2, 4, heartbeat half-period is 2^HB_LOG2 cycles; used only with the optional feature.

Ports:
- clk  input  1  the single clock; all logic is in this domain.
- rst  input  1  reset, asynchronous, active-low. 0 = in reset.
- sw_rst_req  input  1  soft reset request; level-sampled on posedge clk.
- rst_sync_n  output  1  synchronized reset. Asserts asynchronously; deasserts synchronously.
- rst_stage_n  output  NUM_STAGES  staged active-low resets; bit 0 is released first.
- rst_done  output  1  high when every stage is released.
- busy  output  1  high in any state other than DONE.
- soft_cnt  output  8  count of accepted soft resets; saturates at 255.
- hb  output  1  heartbeat; see Optional Feature.

Behaviour:
- Reset values, while rst=0: rst_sync_n=0, rst_stage_n=all 0, rst_done=0, busy=1, soft_cnt=0, hb=0, FSM state=HOLD.
- Reset entry: all registers clear asynchronously when rst falls, including mid-sequence and mid-soft-reset. No clk edge is needed.
- Synchronizer: a chain of SYNC_STAGES flops with D tied to 1, all flops async-cleared by rst. rst_sync_n is the last flop.
  - Number edges E1, E2, ... as the posedges after rst rises.
  - rst_sync_n becomes 1 after edge E_SYNC_STAGES.
- FSM states: HOLD, RELEASE, DONE, SOFT.
- Stage counter: gap_cnt, width $clog2(max(STAGE_GAP,SOFT_CYCLES))+1. Stage index: idx.
- HOLD:
  - Outputs: all stages 0.
  - Transition: on an edge where rst_sync_n is sampled 1, go to RELEASE. rst_stage_n[0] becomes 1 at that edge; idx=1, gap_cnt=0.
- RELEASE:
  - gap_cnt increments each edge.
  - When gap_cnt reaches STAGE_GAP-1, rst_stage_n[idx] becomes 1 at that edge, idx increments and gap_cnt clears.
  - Once the last stage is released, go to DONE at that same edge and set rst_done=1 at that same edge.
  - With the default parameters: stages release after E3, E7 and E11; rst_done=1 after E11.
  - Special case NUM_STAGES=1: the edge that releases stage 0 also enters DONE and sets rst_done.
- DONE:
  - Holds all stages released.
  - If sw_rst_req is sampled 1 at edge Q: go to SOFT; at Q, clear all stages and rst_done, and increment soft_cnt (saturating).
- SOFT:
  - Counts SOFT_CYCLES edges from Q.
  - At edge Q+SOFT_CYCLES: rst_stage_n[0] becomes 1 and the FSM enters RELEASE; the sequence then proceeds as from HOLD.
- sw_rst_req outside DONE: ignored and not counted. A request held high across DONE re-triggers only on the next DONE sample.
- rst_sync_n is never affected by soft reset.
- busy = (state != DONE), registered together with the state.
- Invariant: rst_stage_n is always thermometer-coded; a higher bit is never 1 while a lower bit is 0.

Optional Feature:
- Macro: RST_SEQ_MON_HEARTBEAT_EN.
- Defined:
  - A free-running counter of width HB_LOG2, cleared by rst and held at 0 whenever rst_done=0.
  - hb toggles each time the counter wraps while rst_done=1, giving a period of 2^(HB_LOG2+1) cycles.
  - hb is forced to 0 when rst_done falls.
- Not defined: hb is tied to 0, no counter is built, and the port list is unchanged.

Decomposition:
- Package rst_seq_pkg:
  - state enum rst_seq_state_e {HOLD, RELEASE, DONE, SOFT};
  - SOFT_CNT_W=8 and SOFT_CNT_MAX=255;
  - default parameter constants.
- Sub-module rst_sync_chain (parameter SYNC_STAGES; ports clk, rst, rst_sync_n), reusable elsewhere in the design.

Test Plan:
1. rst low for 5 cycles then high, defaults -> rst_sync_n=1 after E2; rst_stage_n goes 001 after E3, 011 after E7, 111 after E11; rst_done=1 and busy=0 after E11.
2. In DONE, pulse sw_rst_req for 1 cycle at edge Q -> rst_stage_n=000, rst_done=0, soft_cnt=1 after Q; stage0 after Q+8, stage1 after Q+12, stage2 after Q+16.
3. Drop rst low mid-RELEASE (after E8) -> all outputs return to reset values immediately, without a clk edge; the full sequence restarts from E1 after rst rises.
4. sw_rst_req held high during HOLD/RELEASE -> no soft reset and soft_cnt unchanged until DONE is reached; the request is then accepted on the first DONE edge.
5. Issue 260 soft resets -> soft_cnt saturates at 255; a rst pulse clears it to 0.
6. With RST_SEQ_MON_HEARTBEAT_EN and HB_LOG2=4 -> hb toggles every 16 cycles after rst_done; without the macro, hb stays 0 throughout.
